// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit core front end.
package cpu_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    DRAIN,
    HALT
  } fetch_state_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Next-PC selection: redirect target (word aligned) beats sequential advance, else hold.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_addr,
  input  logic            advance,
  output logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc_plus_two
);

  assign pc_plus_two = pc + PC_STEP;

  always_comb begin
    pc_next = pc;
    if (redirect_en) begin
      pc_next = align_pc(redirect_addr);
    end else if (advance) begin
      pc_next = pc_plus_two;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and req/ack instruction-fetch stage feeding decode.
// Optional macro HALT_ON_SELF_JUMP_EN: a jump-to-self parks the unit in HALT until reset.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc_plus_two,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_plus_two;
  logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
  logic [PC_W-1:0]    if_ppt_q, if_ppt_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic               imem_req_q, imem_req_d;
  logic               halt_pend_q, halt_pend_d;
  logic               ack_v, redir_v, advance, self_jump;

  // The request flop is low out of reset, so an ack is only meaningful once it is up.
  assign ack_v   = imem_ack & imem_req_q;
  assign redir_v = redirect_en & (state_q != HALT);

`ifdef HALT_ON_SELF_JUMP_EN
  assign self_jump = (align_pc(redirect_addr) == (if_ppt_q - PC_STEP));
  assign halted    = (state_q == HALT);
`else
  assign self_jump = 1'b0;
  assign halted    = 1'b0;
`endif

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .redirect_en   (redir_v),
    .redirect_addr (redirect_addr),
    .advance       (advance),
    .pc_next       (pc_d),
    .pc_plus_two   (pc_plus_two)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    if_ppt_d     = if_ppt_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    halt_pend_d  = halt_pend_q;
    advance      = 1'b0;

    case (state_q)
      FETCH: begin
        if (redir_v) begin
          if_valid_d = 1'b0;
          if (imem_req_q && !ack_v) begin
            // Handshake in flight: keep the old address on the bus until it completes.
            state_d      = DRAIN;
            drain_addr_d = pc_q;
            halt_pend_d  = self_jump;
          end else begin
            state_d = self_jump ? HALT : FETCH;
          end
        end else if (ack_v) begin
          if_instr_d = imem_rdata;
          if_ppt_d   = pc_plus_two;
          if_valid_d = 1'b1;
          advance    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (redir_v) begin
          if_valid_d = 1'b0;
          state_d    = self_jump ? HALT : FETCH;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (redir_v) begin
          if_valid_d  = 1'b0;
          halt_pend_d = self_jump;
          if (ack_v) state_d = self_jump ? HALT : FETCH;
        end else if (ack_v) begin
          state_d = halt_pend_q ? HALT : FETCH;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase

    imem_req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      if_ppt_q     <= '0;
      if_instr_q   <= '0;
      if_valid_q   <= 1'b0;
      imem_req_q   <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_ppt_q     <= if_ppt_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
      imem_req_q   <= imem_req_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc_plus_two = if_ppt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: memory responder plus an instruction-stream reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus_two;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic        halted;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(16'h0000), .INSTR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc_plus_two (if_pc_plus_two),
    .redirect_en    (redirect_en),
    .redirect_addr  (redirect_addr),
    .halted         (halted)
  );

  int          checks = 0;
  int          errors = 0;
  int          handoffs = 0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  bit          mem_rand = 1'b0;
  bit          model_halted = 1'b0;
  logic [15:0] exp_pc = 16'h0000;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        last_ack = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] ack_q[$];
  logic [15:0] ho_q[$];

  // Memory contents are a fixed function of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // One clock: memory responds, stimulus applied, model updated, then step past the edge.
  task automatic run_cycle(input logic redir, input logic [15:0] raddr, input logic ready);
    last_addr = imem_addr;
    if (imem_req) begin
      checks++;
      if (imem_addr[0] !== 1'b0) begin
        errors++;
        $display("FAIL addr_align: imem_addr=%h, bit 0 must be 0", imem_addr);
      end
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL addr_stable: imem_addr=%h, held request needs %h", imem_addr, prev_addr);
        end
      end
      if (mem_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = 0;
        ack_q.push_back(imem_addr);
        if (mem_rand) mem_lat = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        mem_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
    last_ack  = imem_ack;
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;

    redirect_en   = redir;
    redirect_addr = raddr;
    if_ready      = ready;

    if (if_valid && ready && !redir) begin
      checks++;
      if (if_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL handoff_instr: if_instr=%h, expected %h (pc %h)", if_instr, mem_word(exp_pc), exp_pc);
      end
      checks++;
      if (if_pc_plus_two !== 16'(exp_pc + 16'd2)) begin
        errors++;
        $display("FAIL handoff_ppt: if_pc_plus_two=%h, expected %h", if_pc_plus_two, 16'(exp_pc + 16'd2));
      end
      ho_q.push_back(if_pc_plus_two);
      handoffs++;
      exp_pc = exp_pc + 16'd2;
    end
    if (redir && !model_halted) exp_pc = {raddr[15:1], 1'b0};

    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!if_valid && n < 60) begin
      run_cycle(1'b0, 16'h0000, 1'b0);
      n++;
    end
    checks++;
    if (!if_valid) begin
      errors++;
      $display("FAIL wait_valid: if_valid=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_handoffs(input int count);
    int target = handoffs + count;
    int n = 0;
    while (handoffs < target && n < 200) begin
      run_cycle(1'b0, 16'h0000, 1'b1);
      n++;
    end
    checks++;
    if (handoffs < target) begin
      errors++;
      $display("FAIL wait_handoffs: got %0d handoffs, expected %0d", handoffs, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (imem_req !== 1'b0)              begin errors++; $display("FAIL reset_req: %b, expected 0", imem_req); end
    if (if_valid !== 1'b0)              begin errors++; $display("FAIL reset_valid: %b, expected 0", if_valid); end
    if (if_instr !== 16'h0000)          begin errors++; $display("FAIL reset_instr: %h, expected 0000", if_instr); end
    if (if_pc_plus_two !== 16'h0000)    begin errors++; $display("FAIL reset_ppt: %h, expected 0000", if_pc_plus_two); end
    if (halted !== 1'b0)                begin errors++; $display("FAIL reset_halted: %b, expected 0", halted); end
    if (imem_addr !== 16'h0000)         begin errors++; $display("FAIL reset_addr: %h, expected 0000", imem_addr); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (imem_req !== 1'b1)      begin errors++; $display("FAIL first_req: %b, expected 1", imem_req); end
    if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr: %h, expected 0000", imem_addr); end
    exp_pc = 16'h0000;
  endtask

  task automatic test_sequential();
    logic [15:0] e;
    mem_rand = 1'b0;
    mem_lat  = 1;
    ack_q.delete();
    ho_q.delete();
    wait_handoffs(3);
    for (int i = 0; i < 3; i++) begin
      e = 16'(2 * i);
      checks++;
      if (ack_q.size() <= i || ack_q[i] !== e) begin
        errors++;
        $display("FAIL seq_addr[%0d]: got %h, expected %h", i, (ack_q.size() > i) ? ack_q[i] : 16'hxxxx, e);
      end
      e = 16'(2 * i + 2);
      checks++;
      if (ho_q.size() <= i || ho_q[i] !== e) begin
        errors++;
        $display("FAIL seq_ppt[%0d]: got %h, expected %h", i, (ho_q.size() > i) ? ho_q[i] : 16'hxxxx, e);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    run_cycle(1'b1, 16'hFFFE, 1'b1);
    ho_q.delete();
    wait_handoffs(1);
    checks++;
    if (ho_q.size() < 1 || ho_q[0] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_ppt: got %h, expected 0000", (ho_q.size() > 0) ? ho_q[0] : 16'hxxxx);
    end
    ack_q.delete();
    while (ack_q.size() == 0 && n < 20) begin
      run_cycle(1'b0, 16'h0000, 1'b0);
      n++;
    end
    checks++;
    if (ack_q.size() < 1 || ack_q[0] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_next_addr: got %h, expected 0000", (ack_q.size() > 0) ? ack_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_issue_redirect();
    wait_valid();
    run_cycle(1'b1, 16'h0A13, 1'b1);
    checks += 3;
    if (if_valid !== 1'b0)      begin errors++; $display("FAIL squash_valid: %b, expected 0", if_valid); end
    if (imem_req !== 1'b1)      begin errors++; $display("FAIL squash_req: %b, expected 1", imem_req); end
    if (imem_addr !== 16'h0A12) begin errors++; $display("FAIL squash_addr: %h, expected 0a12", imem_addr); end
    wait_handoffs(1);
  endtask

  task automatic test_drain();
    logic [15:0] old_a;
    int n = 0;
    mem_lat = 3;
    wait_valid();
    run_cycle(1'b0, 16'h0000, 1'b1);
    old_a = exp_pc;
    run_cycle(1'b0, 16'h0000, 1'b0);
    run_cycle(1'b1, 16'h0100, 1'b0);
    last_ack = 1'b0;
    while (!last_ack && n < 10) begin
      run_cycle(1'b0, 16'h0000, 1'b0);
      checks++;
      if (last_addr !== old_a) begin
        errors++;
        $display("FAIL drain_hold: imem_addr=%h, expected %h", last_addr, old_a);
      end
      n++;
    end
    checks += 4;
    if (!last_ack)              begin errors++; $display("FAIL drain_ack: no ack seen, expected one"); end
    if (imem_addr !== 16'h0100) begin errors++; $display("FAIL drain_new_addr: %h, expected 0100", imem_addr); end
    if (imem_req !== 1'b1)      begin errors++; $display("FAIL drain_req: %b, expected 1", imem_req); end
    if (if_valid !== 1'b0)      begin errors++; $display("FAIL drain_valid: %b, expected 0", if_valid); end
    wait_handoffs(1);
    mem_lat = 1;
  endtask

  task automatic test_stall();
    logic [15:0] s_instr, s_ppt;
    wait_valid();
    s_instr = mem_word(exp_pc);
    s_ppt   = exp_pc + 16'd2;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 16'h0000, 1'b0);
      checks += 4;
      if (if_valid !== 1'b1)        begin errors++; $display("FAIL stall_valid[%0d]: %b, expected 1", i, if_valid); end
      if (if_instr !== s_instr)     begin errors++; $display("FAIL stall_instr[%0d]: %h, expected %h", i, if_instr, s_instr); end
      if (if_pc_plus_two !== s_ppt) begin errors++; $display("FAIL stall_ppt[%0d]: %h, expected %h", i, if_pc_plus_two, s_ppt); end
      if (imem_req !== 1'b0)        begin errors++; $display("FAIL stall_req[%0d]: %b, expected 0", i, imem_req); end
    end
    run_cycle(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_random();
    int start = handoffs;
    logic        redir, ready;
    logic [15:0] raddr;
    mem_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      raddr = 16'($urandom);
`ifdef HALT_ON_SELF_JUMP_EN
      if ({raddr[15:1], 1'b0} == 16'(if_pc_plus_two - 16'd2)) raddr = raddr ^ 16'h0010;
`endif
      run_cycle(redir, raddr, ready);
    end
    checks++;
    if (handoffs - start < 50) begin
      errors++;
      $display("FAIL random_progress: %0d handoffs, expected at least 50", handoffs - start);
    end
    mem_rand = 1'b0;
    mem_lat  = 1;
  endtask

  task automatic test_self_jump();
    run_cycle(1'b1, 16'h0040, 1'b0);
    wait_valid();
    checks++;
    if (if_pc_plus_two !== 16'h0042) begin
      errors++;
      $display("FAIL self_ppt: %h, expected 0042", if_pc_plus_two);
    end
    run_cycle(1'b1, 16'h0040, 1'b1);
`ifdef HALT_ON_SELF_JUMP_EN
    model_halted = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks += 3;
      if (halted !== 1'b1)   begin errors++; $display("FAIL halt_flag[%0d]: %b, expected 1", i, halted); end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req[%0d]: %b, expected 0", i, imem_req); end
      if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d]: %b, expected 0", i, if_valid); end
      run_cycle(i == 3, 16'h1234, 1'b1);
    end
`else
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL self_halted: %b, expected 0", halted); end
    ack_q.delete();
    ho_q.delete();
    wait_handoffs(1);
    checks += 2;
    if (ack_q.size() < 1 || ack_q[0] !== 16'h0040) begin
      errors++;
      $display("FAIL self_refetch_addr: got %h, expected 0040", (ack_q.size() > 0) ? ack_q[0] : 16'hxxxx);
    end
    if (ho_q.size() < 1 || ho_q[0] !== 16'h0042) begin
      errors++;
      $display("FAIL self_refetch_ppt: got %h, expected 0042", (ho_q.size() > 0) ? ho_q[0] : 16'hxxxx);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_issue_redirect();
    test_drain();
    test_stall();
    test_random();
    test_self_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
